// File: rtl/data_memory_sized.sv
// Sized-access data memory for the MEM stage: byte/half/word/double loads and stores,
// request/response handshake with RD_LAT-cycle pipelined responses, cleared after every reset.
module data_memory_sized #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int B      = DATA_W / 8;
    localparam int OFF_W  = $clog2(B);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int TOP_LO = OFF_W + IDX_W;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [B-1:0] lane_mask(input logic [1:0] size);
        logic [B-1:0] m;
        int           nb;
        nb = 32'sd1 <<< size;
        for (int i = 0; i < B; i++) begin
            if (i < nb) m[i] = 1'b1;
            else        m[i] = 1'b0;
        end
        return m;
    endfunction

    // Keeps the low 8<<size bits of d and fills the rest with zero or the sign bit.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] d,
                                                      input logic [1:0]        size,
                                                      input logic              uns);
        logic [DATA_W-1:0] v;
        logic              sign;
        int                nbits;
        nbits = 32'sd8 <<< size;
        if (nbits > DATA_W) nbits = DATA_W;
        else                nbits = nbits;
        sign = uns ? 1'b0 : d[nbits-1];
        for (int i = 0; i < DATA_W; i++) begin
            v[i] = (i < nbits) ? d[i] : sign;
        end
        return v;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [IDX_W-1:0]    clear_ptr_r;
    logic                run_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic [OFF_W-1:0]    off_s;
    logic [IDX_W-1:0]    idx_s;
    logic [2:0]          align_mask_s;
    logic                oob_s;
    logic                misal_s;
    logic                bad_size_s;
    logic                err_s;
    logic                accept_s;
    logic                wr_en_s;
    logic [B-1:0]        be_s;
    logic [DATA_W-1:0]   wdata_sh_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic [DATA_W-1:0]   rsp_data_s;

    logic [RD_LAT-1:0]   pipe_valid_r;
    logic [RD_LAT-1:0]   pipe_err_r;
    logic [DATA_W-1:0]   pipe_data_r [RD_LAT];

    // Request decode: alignment, range and size checks plus lane/data steering.
    always_comb begin
        off_s      = req_addr[OFF_W-1:0];
        idx_s      = req_addr[OFF_W +: IDX_W];
        oob_s      = |req_addr[ADDR_W-1:TOP_LO];
        bad_size_s = (req_size == 2'b11) && (DATA_W == 32);
        case (req_size)
            2'b00:   align_mask_s = 3'b000;
            2'b01:   align_mask_s = 3'b001;
            2'b10:   align_mask_s = 3'b011;
            2'b11:   align_mask_s = 3'b111;
            default: align_mask_s = 3'b111;
        endcase
        misal_s    = |(req_addr[2:0] & align_mask_s);
        err_s      = oob_s | misal_s | bad_size_s;
        accept_s   = req_valid & run_r & rst_n;
        wr_en_s    = accept_s & req_write & ~err_s;
        be_s       = lane_mask(req_size) << off_s;
        wdata_sh_s = req_wdata << {off_s, 3'b000};
        rd_word_s  = mem_r[idx_s];
        if (req_write || err_s) begin
            rsp_data_s = '0;
        end else begin
            rsp_data_s = load_extend(rd_word_s >> {off_s, 3'b000}, req_size, req_unsigned);
        end
    end

    // Next-state logic: INIT walks every word once, then RUN until the next reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (clear_ptr_r == IDX_W'(DEPTH - 1)) state_next_s = ST_RUN;
                else                                  state_next_s = ST_INIT;
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_INIT;
        endcase
    end

    // State register, clear pointer and the ready/init_done flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            clear_ptr_r <= '0;
            run_r       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            run_r   <= (state_next_s == ST_RUN);
            if (state_r == ST_INIT) clear_ptr_r <= clear_ptr_r + IDX_W'(1);
            else                    clear_ptr_r <= clear_ptr_r;
        end
    end

    // Storage array: zero-fill during INIT, byte-lane stores during RUN.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            mem_r[clear_ptr_r] <= '0;
        end else if (wr_en_s) begin
            for (int b = 0; b < B; b++) begin
                if (be_s[b]) mem_r[idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
            end
        end
    end

    // Response pipeline; stage 0 captures the load result at the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_valid_r <= '0;
            pipe_err_r   <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_data_r[i] <= '0;
        end else begin
            pipe_valid_r[0] <= accept_s;
            pipe_err_r[0]   <= accept_s & err_s;
            pipe_data_r[0]  <= accept_s ? rsp_data_s : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_err_r[i]   <= pipe_err_r[i-1];
                pipe_data_r[i]  <= pipe_data_r[i-1];
            end
        end
    end

    assign req_ready = run_r;
    assign init_done = run_r;
    assign rsp_valid = pipe_valid_r[RD_LAT-1];
    assign rsp_err   = pipe_err_r[RD_LAT-1];
    assign rsp_rdata = pipe_data_r[RD_LAT-1];

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized (DATA_W=64, DEPTH=256, RD_LAT=2) with hand-computed expectations.
module tb_data_memory_sized;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    int n_cmp = 0;
    int n_bad = 0;

    data_memory_sized #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    // One request, response checked exactly RD_LAT (=2) edges after accept.
    task automatic xfer(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_d, input logic exp_e);
        @(negedge clk);
        drive(wr, sz, uns, addr, wd);
        chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({tag, "_early"}, 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_data"}, rsp_rdata, exp_d);
        chk({tag, "_err"}, 64'(rsp_err), 64'(exp_e));
    endtask

    task automatic wait_init(input string tag);
        int n;
        int ready_early;
        n = 0;
        ready_early = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (req_ready && n < 256) ready_early++;
        end while (!init_done && n < 1000);
        chk({tag, "_cycles"}, 64'(n), 64'd256);
        chk({tag, "_rdy_early"}, 64'(ready_early), 64'd0);
        chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
    endtask

    function automatic logic [63:0] pat(input int i);
        logic [63:0] base;
        base = 64'hC3A5_0F0E_0D0C_0B00;
        return base + 64'(i) * 64'h0000_0101_0000_0011;
    endfunction

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 64'd0;
        req_wdata    = 64'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init1");
        xfer("ld40", 1'b0, 2'b11, 1'b0, 64'h40, 64'd0, 64'd0, 1'b0);

        xfer("st08", 1'b1, 2'b11, 1'b0, 64'h08, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
        xfer("ld08", 1'b0, 2'b11, 1'b0, 64'h08, 64'd0, 64'h1122_3344_5566_7788, 1'b0);
        xfer("lb08s", 1'b0, 2'b00, 1'b0, 64'h08, 64'd0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0);
        xfer("lb08u", 1'b0, 2'b00, 1'b1, 64'h08, 64'd0, 64'h0000_0000_0000_0088, 1'b0);

        xfer("sh0a", 1'b1, 2'b01, 1'b0, 64'h0A, 64'hFFFF_0000_1234_BEEF, 64'd0, 1'b0);
        xfer("ld08h", 1'b0, 2'b11, 1'b0, 64'h08, 64'd0, 64'h1122_3344_BEEF_7788, 1'b0);
        xfer("lh0as", 1'b0, 2'b01, 1'b0, 64'h0A, 64'd0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0);
        xfer("lw0cu", 1'b0, 2'b10, 1'b1, 64'h0C, 64'd0, 64'h0000_0000_1122_3344, 1'b0);

        xfer("lw0a_mis", 1'b0, 2'b10, 1'b0, 64'h0A, 64'd0, 64'd0, 1'b1);
        xfer("sd0c_mis", 1'b1, 2'b11, 1'b0, 64'h0C, 64'h0000_0000_0000_DEAD, 64'd0, 1'b1);
        xfer("ld08_keep", 1'b0, 2'b11, 1'b0, 64'h08, 64'd0, 64'h1122_3344_BEEF_7788, 1'b0);

        xfer("ld800_oob", 1'b0, 2'b11, 1'b0, 64'h800, 64'd0, 64'd0, 1'b1);
        xfer("ldtop_oob", 1'b0, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1'b1);
        xfer("sd7f8", 1'b1, 2'b11, 1'b0, 64'h7F8, 64'hA5A5_5A5A_0102_0304, 64'd0, 1'b0);
        xfer("ld7f8", 1'b0, 2'b11, 1'b0, 64'h7F8, 64'd0, 64'hA5A5_5A5A_0102_0304, 1'b0);

        for (int i = 0; i < 8; i++) begin
            xfer($sformatf("b2b_st%0d", i), 1'b1, 2'b11, 1'b0, 64'(i * 8), pat(i), 64'd0, 1'b0);
        end
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c < 8) drive(1'b0, 2'b11, 1'b0, 64'(c * 8), 64'd0);
            else       req_valid = 1'b0;
            @(posedge clk);
            #1;
            if (c == 0) begin
                chk("b2b_first", 64'(rsp_valid), 64'd0);
            end else begin
                chk($sformatf("b2b_vld%0d", c - 1), 64'(rsp_valid), 64'd1);
                chk($sformatf("b2b_data%0d", c - 1), rsp_rdata, pat(c - 1));
            end
        end
        @(posedge clk);
        #1;
        chk("b2b_tail", 64'(rsp_valid), 64'd0);

        @(negedge clk);
        drive(1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        drive(1'b0, 2'b11, 1'b0, 64'h18, 64'd0);
        @(posedge clk);
        #1;
        chk("inflight_vld", 64'(rsp_valid), 64'd1);
        chk("inflight_data", rsp_rdata, pat(2));
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_run_vld", 64'(rsp_valid), 64'd0);
        chk("rst_run_init_done", 64'(init_done), 64'd0);
        chk("rst_run_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init2");
        xfer("ld08_cleared", 1'b0, 2'b11, 1'b0, 64'h08, 64'd0, 64'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
